// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus output stream of the burst reader, grouped as one bundle.
// Stream rule: a word transfers on any posedge where out_valid && out_ready; once raised, out_valid,
// out_data and out_last hold until that transfer. fifo_ren pops the show-ahead head on the same edge.
interface fifo_burst_reader_if #(
   parameter int DATA_BW = 4
) ();
   logic               fifo_empty;
   logic [DATA_BW-1:0] fifo_rdata;
   logic               fifo_ren;
   logic               out_valid;
   logic               out_ready;
   logic [DATA_BW-1:0] out_data;
   logic               out_last;

   modport master (
      input  fifo_empty, fifo_rdata, out_ready,
      output fifo_ren, out_valid, out_data, out_last
   );

   modport slave (
      output fifo_empty, fifo_rdata, out_ready,
      input  fifo_ren, out_valid, out_data, out_last
   );
endinterface

// File: rtl/fifo_burst_reader.sv
// Read-side burst master for a show-ahead FIFO: pops burst_len words onto a registered stream.
// Optional underrun statistics counter is built only when FIFO_RDR_STATS_EN is defined.
module fifo_burst_reader #(
   parameter int DATA_BW = 4,
   parameter int LEN_BW  = 5,
   parameter int STAT_BW = 16
) (
   input  logic                clk,
   input  logic                reset,
   fifo_burst_reader_if.master bus,
   input  logic                start,
   input  logic [LEN_BW-1:0]   burst_len,
   input  logic                abort,
   output logic                busy,
   output logic                done,
   output logic                aborted,
   output logic [STAT_BW-1:0]  stat_underrun,
   output logic [1:0]          state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [LEN_BW-1:0]   remaining_q, remaining_d;
   logic                out_valid_q, out_valid_d;
   logic                out_last_q, out_last_d;
   logic [DATA_BW-1:0]  out_data_q, out_data_d;
   logic                aborted_q, aborted_d;
   logic                pop;
   logic                accept;

   always_comb begin
      accept = out_valid_q && bus.out_ready;
      // Pop only when the output register is free or being emptied this cycle.
      pop = (state_q == S_RUN) && (remaining_q != '0) && !abort && !bus.fifo_empty &&
            (!out_valid_q || bus.out_ready);

      state_d     = state_q;
      remaining_d = remaining_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      aborted_d   = aborted_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               aborted_d = 1'b0;
               if (burst_len != '0) begin
                  remaining_d = burst_len;
                  state_d     = S_RUN;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_RUN: begin
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = S_DRAIN;
            end else if (pop && (remaining_q == LEN_BW'(1))) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!out_valid_q || accept) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (pop) begin
         out_data_d  = bus.fifo_rdata;
         out_valid_d = 1'b1;
         out_last_d  = (remaining_q == LEN_BW'(1));
         remaining_d = remaining_q - LEN_BW'(1);
      end else if (accept) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         aborted_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
         aborted_q   <= aborted_d;
      end
   end

`ifdef FIFO_RDR_STATS_EN
   logic [STAT_BW-1:0] stat_q, stat_d;

   // Counts RUN cycles starved by the FIFO; saturates instead of wrapping.
   always_comb begin
      stat_d = stat_q;
      if ((state_q == S_IDLE) && start) begin
         stat_d = '0;
      end else if ((state_q == S_RUN) && (remaining_q != '0) && bus.fifo_empty && !abort &&
                   (stat_q != '1)) begin
         stat_d = stat_q + STAT_BW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) stat_q <= '0;
      else       stat_q <= stat_d;
   end

   assign stat_underrun = stat_q;
`else
   assign stat_underrun = '0;
`endif

   assign bus.fifo_ren  = pop;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_DONE);
   assign aborted       = aborted_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural show-ahead FIFO and an output scoreboard.
module tb_fifo_burst_reader;
   localparam int DATA_BW = 4;
   localparam int LEN_BW  = 5;
   localparam int STAT_BW = 16;
`ifdef FIFO_RDR_STATS_EN
   localparam int EXP_UNDERRUN = 5;
`else
   localparam int EXP_UNDERRUN = 0;
`endif

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               start = 1'b0;
   logic [LEN_BW-1:0]  burst_len = '0;
   logic               abort = 1'b0;
   logic               busy, done, aborted;
   logic [STAT_BW-1:0] stat_underrun;
   logic [1:0]         state_dbg;

   int test_cnt = 0;
   int fail_cnt = 0;
   int ren_cnt  = 0;

   // Behavioural FIFO: main process writes, the pop process advances the read pointer.
   logic [DATA_BW-1:0] mem [16];
   logic [7:0]         wr_ptr = '0;
   logic [7:0]         rd_ptr = '0;
   logic               flush_req = 1'b0;
   logic [DATA_BW:0]   exp_q [$];
   logic [DATA_BW:0]   sb_w;

   always #5 clk = ~clk;

   fifo_burst_reader_if #(.DATA_BW(DATA_BW)) bus ();

   assign bus.fifo_empty = (wr_ptr == rd_ptr);
   assign bus.fifo_rdata = mem[rd_ptr[3:0]];

   fifo_burst_reader #(
      .DATA_BW(DATA_BW), .LEN_BW(LEN_BW), .STAT_BW(STAT_BW)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus), .start(start), .burst_len(burst_len),
      .abort(abort), .busy(busy), .done(done), .aborted(aborted),
      .stat_underrun(stat_underrun), .state_dbg(state_dbg)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      test_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) begin
      if (flush_req)         rd_ptr <= wr_ptr;
      else if (bus.fifo_ren) rd_ptr <= rd_ptr + 8'd1;
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.out_valid && bus.out_ready) begin
            check("sb_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               sb_w = exp_q.pop_front();
               check("sb_data", 32'(bus.out_data), 32'(sb_w[DATA_BW-1:0]));
               check("sb_last", 32'(bus.out_last), 32'(sb_w[DATA_BW]));
            end
         end
         if (bus.out_valid && !bus.out_ready) check("stall_no_pop", 32'(bus.fifo_ren), 32'd0);
         if (bus.fifo_ren) ren_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_fifo(input logic [DATA_BW-1:0] d);
      mem[wr_ptr[3:0]] = d;
      wr_ptr = wr_ptr + 8'd1;
   endtask

   task automatic expect_word(input logic [DATA_BW-1:0] d, input logic last);
      exp_q.push_back({last, d});
   endtask

   task automatic do_start(input logic [LEN_BW-1:0] len);
      start = 1'b1;
      burst_len = len;
      tick();
      start = 1'b0;
      burst_len = '0;
   endtask

   task automatic flush_fifo();
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
   endtask

   // Drives out_ready from an 8-cycle pattern until done is seen at a negedge.
   task automatic run_until_done(input int budget, input logic [7:0] pat,
                                 output int cycles, output logic seen, output logic ab);
      cycles = 0;
      seen = 1'b0;
      ab = 1'b0;
      for (int i = 0; i < budget; i++) begin
         bus.out_ready = pat[i % 8];
         @(negedge clk);
         cycles++;
         if (done) begin
            seen = 1'b1;
            ab = aborted;
            break;
         end
         tick();
      end
      tick();
   endtask

   initial begin
      int cyc;
      int ren0;
      logic seen, ab;

      bus.out_ready = 1'b0;
      repeat (3) tick();
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_last",  32'(bus.out_last), 32'd0);
      check("rst_out_data",  32'(bus.out_data), 32'd0);
      check("rst_done",      32'(done), 32'd0);
      check("rst_aborted",   32'(aborted), 32'd0);
      check("rst_busy",      32'(busy), 32'd0);
      check("rst_stat",      32'(stat_underrun), 32'd0);
      check("rst_state",     32'(state_dbg), 32'd0);
      reset = 1'b0;
      tick();

      // Full-throughput burst of 4
      push_fifo(4'hA); push_fifo(4'hB); push_fifo(4'hC); push_fifo(4'hD);
      expect_word(4'hA, 1'b0); expect_word(4'hB, 1'b0);
      expect_word(4'hC, 1'b0); expect_word(4'hD, 1'b1);
      bus.out_ready = 1'b1;
      ren0 = ren_cnt;
      do_start(5'd4);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t1_ren_consecutive", 32'(bus.fifo_ren), 32'd1);
         tick();
      end
      run_until_done(20, 8'hFF, cyc, seen, ab);
      check("t1_done_seen", 32'(seen), 32'd1);
      check("t1_done_latency", 32'(cyc), 32'd2);
      check("t1_aborted", 32'(ab), 32'd0);
      check("t1_ren_count", 32'(ren_cnt - ren0), 32'd4);
      check("t1_fifo_empty", 32'(bus.fifo_empty), 32'd1);
      check("t1_sb_drained", 32'(exp_q.size()), 32'd0);
      check("t1_idle", 32'(busy), 32'd0);

      // Backpressure with alternating out_ready
      for (int k = 1; k <= 6; k++) begin
         push_fifo(DATA_BW'(k));
         expect_word(DATA_BW'(k), k == 6);
      end
      ren0 = ren_cnt;
      do_start(5'd6);
      run_until_done(60, 8'h55, cyc, seen, ab);
      check("t2_done_seen", 32'(seen), 32'd1);
      check("t2_ren_count", 32'(ren_cnt - ren0), 32'd6);
      check("t2_sb_drained", 32'(exp_q.size()), 32'd0);
      check("t2_fifo_empty", 32'(bus.fifo_empty), 32'd1);

      // Starved RUN for 5 cycles, then the words arrive
      bus.out_ready = 1'b1;
      do_start(5'd3);
      repeat (5) tick();
      check("t3_busy", 32'(busy), 32'd1);
      check("t3_no_output", 32'(bus.out_valid), 32'd0);
      check("t3_underrun", 32'(stat_underrun), 32'(EXP_UNDERRUN));
      push_fifo(4'h7); push_fifo(4'h8); push_fifo(4'h9);
      expect_word(4'h7, 1'b0); expect_word(4'h8, 1'b0); expect_word(4'h9, 1'b1);
      run_until_done(20, 8'hFF, cyc, seen, ab);
      check("t3_done_seen", 32'(seen), 32'd1);
      check("t3_underrun_final", 32'(stat_underrun), 32'(EXP_UNDERRUN));
      check("t3_sb_drained", 32'(exp_q.size()), 32'd0);

      // Zero-length burst
      ren0 = ren_cnt;
      do_start(5'd0);
      run_until_done(5, 8'hFF, cyc, seen, ab);
      check("t4_done_seen", 32'(seen), 32'd1);
      check("t4_done_latency", 32'(cyc), 32'd1);
      check("t4_aborted", 32'(ab), 32'd0);
      check("t4_ren_count", 32'(ren_cnt - ren0), 32'd0);
      check("t4_stat_cleared", 32'(stat_underrun), 32'd0);

      // Abort with a held word
      for (int k = 0; k < 6; k++) push_fifo(DATA_BW'(4'h8 + k));
      expect_word(4'h8, 1'b0); expect_word(4'h9, 1'b0);
      ren0 = ren_cnt;
      bus.out_ready = 1'b1;
      do_start(5'd6);
      tick();
      tick();
      bus.out_ready = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      check("t5_ren_on_abort", 32'(bus.fifo_ren), 32'd0);
      tick();
      abort = 1'b0;
      check("t5_state_drain", 32'(state_dbg), 32'd2);
      check("t5_held_valid", 32'(bus.out_valid), 32'd1);
      check("t5_held_data", 32'(bus.out_data), 32'h9);
      @(negedge clk);
      check("t5_ren_in_drain", 32'(bus.fifo_ren), 32'd0);
      tick();
      run_until_done(20, 8'hFF, cyc, seen, ab);
      check("t5_done_seen", 32'(seen), 32'd1);
      check("t5_aborted", 32'(ab), 32'd1);
      check("t5_ren_count", 32'(ren_cnt - ren0), 32'd2);
      check("t5_fifo_level", 32'(8'(wr_ptr - rd_ptr)), 32'd4);
      check("t5_fifo_not_empty", 32'(bus.fifo_empty), 32'd0);
      check("t5_sb_drained", 32'(exp_q.size()), 32'd0);
      flush_fifo();

      // Reset in the middle of a stalled burst, then a clean burst of 2
      for (int k = 0; k < 4; k++) push_fifo(DATA_BW'(4'h1 + k));
      bus.out_ready = 1'b0;
      do_start(5'd4);
      tick();
      check("t6_pre_state", 32'(state_dbg), 32'd1);
      check("t6_pre_valid", 32'(bus.out_valid), 32'd1);
      reset = 1'b1;
      tick();
      check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      flush_fifo();
      push_fifo(4'hE); push_fifo(4'hF);
      expect_word(4'hE, 1'b0); expect_word(4'hF, 1'b1);
      bus.out_ready = 1'b1;
      do_start(5'd2);
      run_until_done(20, 8'hFF, cyc, seen, ab);
      check("t6_done_seen", 32'(seen), 32'd1);
      check("t6_aborted", 32'(ab), 32'd0);
      check("t6_sb_drained", 32'(exp_q.size()), 32'd0);

      tick();
      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule
